// File: rtl/seq_div_rem.sv
// seq_div_rem -- multi-cycle radix-2 restoring divider / remainder unit.
//
// Covers DIV, DIVU, REM and REMU for the execute stage. It resolves one
// quotient bit per clock, so the pipeline stalls while busy is high.
//
// Optional build macro: SEQ_DIV_FAST_SPECIAL_EN
//   When it is defined, divide-by-zero and signed overflow (MIN / -1) are
//   detected in IDLE. These cases then complete on the accepting edge, and
//   done follows one cycle after start.
//   When it is undefined, these cases take the full iteration path, and the
//   overrides are applied in FIX. The result values match in both builds.
//
// Handshake: start is sampled only in IDLE, and only when flush is low.
//   busy is high while iterating or fixing up.
//   done pulses for exactly one cycle. While done is high, result is valid
//   and busy is low.
//   result holds its value until the next completion.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high
//   start     in   request (sampled in IDLE only)
//   op        in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  in   rs1 value, captured on accepted start
//   divisor   in   rs2 value, captured on accepted start
//   flush     in   abort current operation (CALC/FIX), block start in IDLE
//   busy      out  operation in progress
//   done      out  one-cycle completion pulse
//   result    out  quotient or remainder according to captured op
module seq_div_rem #(
   parameter int DATA_WIDTH = 32,
   localparam int CNT_W = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_q, result_q;
   logic [1:0]            op_q;
   logic                  q_neg_q, r_neg_q, dz_q, ovf_q;
   logic [CNT_W-1:0]      cnt_q;

   // Input-side decode, used on the accepting edge.
   logic                  in_signed, dvd_neg, dvs_neg, in_dz, in_ovf;
   logic [DATA_WIDTH-1:0] dvd_mag, dvs_mag;
   logic                  accept, fast_hit;

   assign in_signed = ~op[0];
   assign dvd_neg   = in_signed & dividend[DATA_WIDTH-1];
   assign dvs_neg   = in_signed & divisor[DATA_WIDTH-1];
   assign dvd_mag   = dvd_neg ? -dividend : dividend;
   assign dvs_mag   = dvs_neg ? -divisor  : divisor;
   assign in_dz     = (divisor == '0);
   assign in_ovf    = in_signed && (dividend == MIN_VAL) && (divisor == '1);
   assign accept    = (state == ST_IDLE) && start && !flush;

`ifdef SEQ_DIV_FAST_SPECIAL_EN
   logic [DATA_WIDTH-1:0] fast_result;
   assign fast_hit    = in_dz | in_ovf;
   // Divide-by-zero takes priority: quotient all ones, remainder = dividend.
   // Overflow: quotient MIN, remainder 0.
   assign fast_result = op[1] ? (in_dz ? dividend : '0)
                              : (in_dz ? '1 : MIN_VAL);
`else
   assign fast_hit = 1'b0;
`endif

   // One restoring step. rem is always below the divisor magnitude, so the
   // shifted remainder fits in DATA_WIDTH+1 bits. The top bit of the trial
   // difference is the borrow.
   logic [DATA_WIDTH:0] rem_sh, trial;
   logic                no_borrow;

   assign rem_sh    = {rem_q, quo_q[DATA_WIDTH-1]};
   assign trial     = rem_sh - {1'b0, dvs_q};
   assign no_borrow = ~trial[DATA_WIDTH];

   // Sign correction followed by the architectural special-case overrides.
   logic [DATA_WIDTH-1:0] fix_q, fix_r, fix_result;

   always_comb begin
      fix_q = q_neg_q ? -quo_q : quo_q;
      fix_r = r_neg_q ? -rem_q : rem_q;
      if (dz_q) begin
         fix_q = '1;
         fix_r = dvd_q;
      end else if (ovf_q) begin
         fix_q = MIN_VAL;
         fix_r = '0;
      end
      fix_result = op_q[1] ? fix_r : fix_q;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // FSM next state.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = fast_hit ? ST_DONE : ST_CALC;
         ST_CALC: begin
            if (flush)                     state_nxt = ST_IDLE;
            else if (cnt_q == CNT_W'(1))   state_nxt = ST_FIX;
         end
         ST_FIX:  state_nxt = flush ? ST_IDLE : ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         dvd_q    <= '0;
         result_q <= '0;
         op_q     <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               op_q    <= op;
               dvd_q   <= dividend;
               dvs_q   <= dvs_mag;
               rem_q   <= '0;
               quo_q   <= dvd_mag;
               q_neg_q <= dvd_neg ^ dvs_neg;
               r_neg_q <= dvd_neg;
               dz_q    <= in_dz;
               ovf_q   <= in_ovf;
               cnt_q   <= CNT_W'(DATA_WIDTH);
`ifdef SEQ_DIV_FAST_SPECIAL_EN
               if (fast_hit) result_q <= fast_result;
`endif
            end
            ST_CALC: if (!flush) begin
               rem_q <= no_borrow ? trial[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
               quo_q <= {quo_q[DATA_WIDTH-2:0], no_borrow};
               cnt_q <= cnt_q - CNT_W'(1);
            end
            ST_FIX: if (!flush) result_q <= fix_result;
            default: ;
         endcase
      end
   end

   assign busy   = (state == ST_CALC) || (state == ST_FIX);
   assign done   = (state == ST_DONE);
   assign result = result_q;

endmodule

// File: doc/seq_div_rem.md
Name: seq_div_rem

Overview:
- Multi-cycle radix-2 restoring divider/remainder unit for the RV32IM execute stage.
- Supersedes the combinational divide/remainder blocks with one unit covering signed and unsigned DIV, DIVU, REM and REMU.
- Parametrised in data width.
- Uses a start/busy/done handshake, so the CPU stalls the pipeline while busy is high instead of closing timing through a 32-bit combinational divider.

Parameters:
- DATA_WIDTH, 32: operand and result width in bits, minimum 4.
- CNT_W, $clog2(DATA_WIDTH)+1: width of the iteration counter (derived, do not override).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  DATA_WIDTH  rs1 value, captured on an accepted start.
- divisor  in  DATA_WIDTH  rs2 value, captured on an accepted start.
- flush  in  1  abort the current operation (pipeline flush/trap).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  DATA_WIDTH  quotient or remainder, selected by the captured op.

Behaviour:
- Reset: asynchronous, active-high, clock clk. On reset: state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers=0. Reset mid-operation aborts immediately and no done is produced.
- IDLE:
  - On start=1, capture op, dividend and divisor.
  - For signed ops (op[0]=0), convert operands to magnitudes and record quotient sign (signs differ) and remainder sign (dividend sign).
  - Go to CALC with counter=DATA_WIDTH.
- CALC, one quotient bit per cycle:
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor magnitude from rem using a DATA_WIDTH+1 bit subtractor.
  - If no borrow, keep the difference and set quo LSB=1.
  - Decrement the counter; at 0, go to FIX.
- FIX:
  - Apply sign correction: negate quo if the quotient sign is set; negate rem if the remainder sign is set.
  - Apply RISC-V special-case overrides:
    - divisor==0: quotient=all ones, remainder=original dividend, for both signed and unsigned ops.
    - Signed overflow (dividend=MIN, divisor=-1): quotient=MIN, remainder=0.
  - Load result, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in this cycle, then return to IDLE. A start seen in the DONE cycle is ignored.
- Latency: done is high DATA_WIDTH+2 cycles after the edge that accepted start, so 34 cycles for DATA_WIDTH=32.
- result holds its value until the next FIX (or fast-path completion) and is not cleared by the next start.
- start while busy is ignored; operand inputs need only be valid in the start cycle.
- flush=1 in CALC or FIX: return to IDLE on the next edge with no done and result unchanged. flush in IDLE or DONE has no effect; the done pulse in progress still occurs.
- Simultaneous flush and start in IDLE: flush wins and the request is dropped.
- All arithmetic is modulo 2^DATA_WIDTH; negation is two's complement.

Optional Feature:
- Macro: SEQ_DIV_FAST_SPECIAL_EN.
- When defined:
  - In IDLE, divide-by-zero and signed overflow are detected combinationally on the input operands.
  - The unit goes straight to DONE with the override result loaded on the accepting edge: done one cycle after start, busy never asserted.
- When undefined: these cases take the full DATA_WIDTH+2 latency, with the overrides applied in FIX. Final result values are identical in both builds.

Test Plan:
1. DIVU, 100 / 7, DATA_WIDTH=32: done exactly 34 cycles after start; result=14. Repeat with REMU: result=2.
2. DIV, -100 / 7: result=0xFFFFFFF2 (-14). Repeat with REM: result=0xFFFFFFFE (-2). Check busy high for cycles 1..33.
3. DIV, 0x80000000 / 0xFFFFFFFF: result=0x80000000. REM on the same operands: result=0.
4. DIVU, 0x1234 / 0: result=0xFFFFFFFF. REM, 0x1234 / 0: result=0x1234. Latency is 34 cycles without SEQ_DIV_FAST_SPECIAL_EN and 1 cycle with it.
5. Start DIVU 50/5, assert flush at cycle 10: no done, result keeps the prior value, busy=0 next cycle. Then start DIVU 9/3: result=3 at cycle 34.
6. Assert reset mid-CALC: busy, done and result are 0 immediately (asynchronous). Pulse start during busy: it is ignored and only one done occurs.
